// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard front end
// (host transmitter, receiver, clock filter).
package ps2_pkg;

  // Default depth of the ps2c glitch filter; the receiver uses the same value.
  localparam int FILTER_LEN_DEFAULT = 8;

  // Host-to-keyboard command bytes.
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // Host transmitter state encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RTS    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5,
    DONE   = 3'd6
  } tx_state_t;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: debounces the sampled PS/2 clock pin and flags its
// falling edges. A new level is accepted only after FILTER_LEN identical
// consecutive samples; anything in between holds the previous level.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c_in,
  output logic ps2c_f,
  output logic fall_tick
);

  logic [FILTER_LEN-1:0] r_filter;
  logic                  r_fclk;
  logic [FILTER_LEN-1:0] w_filter_next;
  logic                  w_fclk_next;

  assign w_filter_next = {ps2c_in, r_filter[FILTER_LEN-1:1]};

  // Accept a new filtered level only when the whole window agrees.
  always_comb begin
    w_fclk_next = r_fclk;
    if (&w_filter_next) begin
      w_fclk_next = 1'b1;
    end else if (~|w_filter_next) begin
      w_fclk_next = 1'b0;
    end
  end

  // Sample history and filtered level; the idle PS/2 clock is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filter <= '1;
      r_fclk   <= 1'b1;
    end else begin
      r_filter <= w_filter_next;
      r_fclk   <= w_fclk_next;
    end
  end

  assign ps2c_f    = r_fclk;
  // High in the cycle whose clock edge moves the filtered level from 1 to 0.
  assign fall_tick = r_fclk & ~w_fclk_next;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter for one command byte.
// Build option: define PS2_HOST_TX_TIMEOUT_EN to add a watchdog between
// device clock edges (parameter TIMEOUT_CYCLES exists only in that build).
//
// Handshake: wr_ps2 is a single-cycle request that is accepted only while
// tx_idle=1 (tx_idle is the ready); requests in any other cycle are dropped.
// Every accepted request ends with exactly one tx_done_tick, with tx_err
// valid in that same cycle, unless rst aborts the transfer first.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = FILTER_LEN_DEFAULT
`ifdef PS2_HOST_TX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err,
  output tx_state_t  dbg_state
);

  localparam int CW = $clog2(INHIBIT_CYCLES + 1);

  tx_state_t r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_parity, w_parity_next;
  logic [2:0]    r_idx, w_idx_next;
  logic          r_err, w_err_next;
  logic          r_done, w_done_next;
  logic          r_c_oe, w_c_oe_next;
  logic          r_d_oe, w_d_oe_next;
  logic          w_ps2c_f;
  logic          w_fall;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wd, w_wd_next;
`endif

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .ps2c_in  (ps2c_in),
    .ps2c_f   (w_ps2c_f),
    .fall_tick(w_fall)
  );

  // Next-state logic: each state reacts only to its own event, so a
  // fall_tick coinciding with wr_ps2 is handled by whichever state is current.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    w_idx_next    = r_idx;
    w_err_next    = r_err;
    w_done_next   = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    w_wd_next     = '0;
`endif
    case (r_state)
      IDLE: begin
        if (wr_ps2) begin
          w_shift_next  = din;
          w_parity_next = odd_parity(din);
          w_err_next    = 1'b0;
          w_cnt_next    = CW'(INHIBIT_CYCLES - 1);
          w_state_next  = RTS;
        end
      end
      RTS: begin
        // Clock held low for INHIBIT_CYCLES cycles: counts N-1 down to 0.
        if (r_cnt == '0) begin
          w_state_next = START;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      START: begin
        if (w_fall) begin
          w_idx_next   = 3'd0;
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_fall) begin
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_state_next = PARITY;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (w_fall) begin
          w_state_next = STOP;
        end
      end
      STOP: begin
        // Device acknowledges by pulling data low at the eleventh falling edge.
        if (w_fall) begin
          w_err_next   = ps2d_in;
          w_state_next = DONE;
        end
      end
      DONE: begin
        // Wait for the device to release both lines before reporting.
        if (w_ps2c_f && ps2d_in) begin
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
    // Watchdog runs while waiting for device clocks; RTS/IDLE keep it at
    // zero, which also clears it on entry to START.
    if (r_state inside {START, DATA, PARITY, STOP, DONE}) begin
      if (w_fall) begin
        w_wd_next = '0;
      end else if (r_wd == WW'(TIMEOUT_CYCLES - 1)) begin
        w_wd_next    = '0;
        w_err_next   = 1'b1;
        w_done_next  = 1'b1;
        w_state_next = IDLE;
      end else begin
        w_wd_next = r_wd + WW'(1);
      end
    end
`endif
  end

  // Line drive decoded from next-state values so the oe outputs are flops.
  always_comb begin
    w_c_oe_next = 1'b0;
    w_d_oe_next = 1'b0;
    case (w_state_next)
      RTS:     w_c_oe_next = 1'b1;
      START:   w_d_oe_next = 1'b1;
      DATA:    w_d_oe_next = ~w_shift_next[0];
      PARITY:  w_d_oe_next = ~w_parity_next;
      default: begin
        w_c_oe_next = 1'b0;
        w_d_oe_next = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset releases both lines immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_c_oe   <= 1'b0;
      r_d_oe   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_shift  <= w_shift_next;
      r_parity <= w_parity_next;
      r_idx    <= w_idx_next;
      r_err    <= w_err_next;
      r_done   <= w_done_next;
      r_c_oe   <= w_c_oe_next;
      r_d_oe   <= w_d_oe_next;
    end
  end

`ifdef PS2_HOST_TX_TIMEOUT_EN
  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd <= '0;
    end else begin
      r_wd <= w_wd_next;
    end
  end
`endif

  assign ps2c_oe      = r_c_oe;
  assign ps2d_oe      = r_d_oe;
  assign tx_idle      = (r_state == IDLE);
  assign tx_done_tick = r_done;
  assign tx_err       = r_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model
// that clocks the frame, samples data on rising edges and optionally ACKs.
// Define PS2_HOST_TX_TIMEOUT_EN to also exercise the watchdog.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF       = 25;
  localparam int INHIBIT    = 5000;
  localparam int FLEN       = 8;
  localparam int TB_TIMEOUT = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err;
  tx_state_t  dbg_state;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rts_cycles = 0;
  logic last_err = 1'b0;

  logic [0:0] exp_q[$];

  // Open-collector wiring: either side can pull a line low.
  assign ps2c_in = dev_clk & ~ps2c_oe;
  assign ps2d_in = dev_data & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .FILTER_LEN    (FLEN)
`ifdef PS2_HOST_TX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TB_TIMEOUT)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c_in     (ps2c_in),
    .ps2d_in     (ps2d_in),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_err      (tx_err),
    .dbg_state   (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Monitor: counts done pulses, latches tx_err with them, counts RTS cycles.
  always @(posedge clk) begin
    if (tx_done_tick) begin
      done_cnt <= done_cnt + 1;
      last_err <= tx_err;
    end
    if (ps2c_oe) rts_cycles <= rts_cycles + 1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare one line sample with the head of the expected queue.
  task automatic sb_check(input string tag, input logic obs);
    logic [0:0] e;
    if (exp_q.size() == 0) begin
      chk1({tag, "_queue_empty"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      chk1(tag, obs, e[0]);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic par);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(par);
    exp_q.push_back(1'b1);
  endtask

  // Device model: wait for the start condition, then generate n_edges clocks.
  task automatic run_device(input string tag, input logic ack, input int n_edges,
                            input logic do_wr, input logic [7:0] wr_din);
    int n;
    n = 0;
    while (!(ps2c_oe == 1'b0 && ps2d_oe == 1'b1) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk1({tag, "_start_seen"}, (n < 10000), 1'b1);
    repeat (HALF) @(negedge clk);
    sb_check({tag, "_start_bit"}, ps2d_in);
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11) dev_data = ack ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      for (int c = 0; c < HALF; c++) begin
        @(negedge clk);
        if (do_wr && k == 4 && c == 2) begin
          wr_ps2 = 1'b1;
          din    = wr_din;
        end else begin
          wr_ps2 = 1'b0;
        end
      end
      if (k <= 10) sb_check($sformatf("%s_edge%0d", tag, k), ps2d_in);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input string tag, input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk1({tag, "_done_seen"}, (done_cnt != prev), 1'b1);
    repeat (20) @(negedge clk);
    chk32({tag, "_done_count"}, done_cnt - prev, 1);
  endtask

  // Full transfer: request, device frame, completion checks.
  task automatic send(input string tag, input logic [7:0] d, input logic par,
                      input logic ack, input logic exp_err,
                      input logic do_wr, input logic [7:0] wr_din);
    int rts0, done0;
    rts0  = rts_cycles;
    done0 = done_cnt;
    push_frame(d, par);
    @(negedge clk);
    din = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din = 8'h5A;
    chk1({tag, "_busy"}, tx_idle, 1'b0);
    run_device(tag, ack, 11, do_wr, wr_din);
    wait_done(tag, done0);
    chk1({tag, "_err_at_done"}, last_err, exp_err);
    chk1({tag, "_err_held"}, tx_err, exp_err);
    chk1({tag, "_idle"}, tx_idle, 1'b1);
    chk32({tag, "_rts_cycles"}, rts_cycles - rts0, INHIBIT);
    chk32({tag, "_queue_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int done0;
    int n;
    // Reset block
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk1("rst_c_oe", ps2c_oe, 1'b0);
    chk1("rst_d_oe", ps2d_oe, 1'b0);
    chk1("rst_idle", tx_idle, 1'b1);
    chk1("rst_done", tx_done_tick, 1'b0);
    chk1("rst_err", tx_err, 1'b0);
    chk1("rst_state", (dbg_state == IDLE), 1'b1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xED set-LEDs with ACK: bits 1,0,1,1,0,1,1,1, parity 1
    send("set_led", CMD_SET_LED, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    // Parity corners
    send("par_01", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send("par_00", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    send("par_ff", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    // Missing ACK
    send("no_ack", CMD_SET_LED, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    // Second request during DATA is dropped; 0xEE stays on the wire
    send("wr_ignored", CMD_ECHO, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);

    // Reset during PARITY
    done0 = done_cnt;
    push_frame(CMD_SET_LED, 1'b1);
    @(negedge clk);
    din = CMD_SET_LED;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    run_device("abort", 1'b1, 9, 1'b0, 8'h00);
    chk1("abort_in_parity", (dbg_state == PARITY), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("abort_c_oe", ps2c_oe, 1'b0);
    chk1("abort_d_oe", ps2d_oe, 1'b0);
    chk1("abort_idle", tx_idle, 1'b1);
    repeat (50) @(negedge clk);
    chk32("abort_no_done", done_cnt - done0, 0);
    exp_q.delete();
    send("after_abort", CMD_RESET, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    // Device stops after edge 4; watchdog restarts at that edge's fall_tick,
    // which the filter reports FLEN cycles after the line drops.
    push_frame(8'h55, 1'b1);
    @(negedge clk);
    din = 8'h55;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    run_device("tmo", 1'b1, 3, 1'b0, 8'h00);
    dev_clk = 1'b0;
    n = 0;
    while (n < TB_TIMEOUT + 200) begin
      @(negedge clk);
      n++;
      if (n == HALF) dev_clk = 1'b1;
      if (tx_done_tick) break;
    end
    chk32("tmo_cycles", n, TB_TIMEOUT + FLEN);
    chk1("tmo_c_oe", ps2c_oe, 1'b0);
    chk1("tmo_d_oe", ps2d_oe, 1'b0);
    chk1("tmo_err", tx_err, 1'b1);
    chk1("tmo_idle", tx_idle, 1'b1);
    exp_q.delete();
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
